// File: rtl/alu_seq_pkg.sv
// Shared op encodings, sequencer state type and ALU control mapping for alu_op_sequencer.
package alu_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } seq_state_t;

    // Returns {ALUOp1, ALUOp0}; reserved drives the add encoding.
    function automatic logic [1:0] op_to_aluop(input logic [1:0] op);
        case (op)
            OP_SUB:  return 2'b01;
            OP_MUL:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and occupancy count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues queued add/sub/mul commands to a combinational ALU one at a time and
// returns each settled result with its tag in command order.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TAG_W         = 3,
    parameter int ADDSUB_SETTLE = 1,
    parameter int MUL_SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4:0]       cmd_a,
    input  logic [4:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [4:0]       alu_a,
    output logic [4:0]       alu_b,
    output logic             alu_op0,
    output logic             alu_op1,
    input  logic [10:0]      alu_d,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [10:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);
    localparam int FW    = 12 + TAG_W;
    localparam int CNT_W = 8;

    seq_state_t             state, state_nxt;
    logic [FW-1:0]          fifo_wdata, fifo_rdata;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [1:0]             head_op;
    logic [4:0]             head_a, head_b;
    logic [TAG_W-1:0]       head_tag, cur_tag;
    logic                   cur_rsv;
    logic [CNT_W-1:0]       cnt;
    logic                   issue, capture, res_clr;

    assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;
    assign cmd_ready  = !fifo_full;
    assign busy       = (fifo_count != '0) || (state != S_IDLE);

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        res_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    issue     = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_clr = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        issue     = 1'b1;
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reserved ops skip the settle load and take one fixed pass through EXEC,
    // giving them the two-cycle result latency with a zero/error result.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op0   <= 1'b0;
            alu_op1   <= 1'b0;
            cur_tag   <= '0;
            cur_rsv   <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else begin
            if (issue) begin
                alu_a              <= head_a;
                alu_b              <= head_b;
                {alu_op1, alu_op0} <= op_to_aluop(head_op);
                cur_tag            <= head_tag;
                cur_rsv            <= (head_op == OP_RSV);
                if (head_op == OP_RSV)      cnt <= CNT_W'(1);
                else if (head_op == OP_MUL) cnt <= CNT_W'(MUL_SETTLE);
                else                        cnt <= CNT_W'(ADDSUB_SETTLE);
            end else if (state == S_EXEC) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= cur_rsv ? 11'd0 : alu_d;
                res_err   <= cur_rsv;
                res_tag   <= cur_tag;
            end else if (res_clr) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 5-bit add/sub/mul ALU.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_tag;
    logic [4:0]  alu_a, alu_b;
    logic        alu_op0, alu_op1;
    logic [10:0] alu_d;
    logic        res_valid, res_ready;
    logic [10:0] res_data;
    logic [2:0]  res_tag;
    logic        res_err, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Combinational ALU: ALUOp1/ALUOp0 = 00 add, 01 sub, 10 mul.
    always_comb begin
        alu_d = 11'd0;
        case ({alu_op1, alu_op0})
            2'b00:   alu_d = {6'd0, alu_a} + {6'd0, alu_b};
            2'b01:   alu_d = {6'd0, alu_a} - {6'd0, alu_b};
            2'b10:   alu_d = {6'd0, alu_a} * {6'd0, alu_b};
            default: alu_d = 11'd0;
        endcase
    end

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op0(alu_op0), .alu_op1(alu_op1),
        .alu_d(alu_d),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [2:0] tag);
        int n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("send_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
    endtask

    initial begin
        int lat, sent, got, vcnt;
        logic acc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        res_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data",  res_data, 0);
        chk("rst_res_tag_err", {res_tag, res_err}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op1, alu_op0}, 0);
        chk("rst_busy", busy, 0);

        // add 13+9
        send(2'b00, 5'd13, 5'd9, 3'd5);
        wait_res(lat);
        chk("add_lat", lat, 2);
        chk("add_data", res_data, 22);
        chk("add_tag", res_tag, 5);
        chk("add_err", res_err, 0);
        tick(); tick();
        chk("add_idle_busy", busy, 0);

        // mul 31*31, operands stable throughout EXEC
        send(2'b10, 5'd31, 5'd31, 3'd3);
        tick();
        chk("mul_e1_ops", {alu_a, alu_b, alu_op1, alu_op0}, {5'd31, 5'd31, 2'b10});
        tick();
        chk("mul_e2_ops", {alu_a, alu_b}, {5'd31, 5'd31});
        chk("mul_e2_nvalid", res_valid, 0);
        tick();
        chk("mul_valid", res_valid, 1);
        chk("mul_data", res_data, 961);
        chk("mul_tag", res_tag, 3);

        // reserved then sub
        send(2'b11, 5'd4, 5'd4, 3'd2);
        wait_res(lat);
        chk("rsv_lat", lat, 2);
        chk("rsv_data", res_data, 0);
        chk("rsv_err", res_err, 1);
        chk("rsv_tag", res_tag, 2);
        send(2'b01, 5'd20, 5'd6, 3'd1);
        wait_res(lat);
        chk("sub_lat", lat, 2);
        chk("sub_data", res_data, 14);
        chk("sub_err", res_err, 0);
        tick(); tick();

        // backpressure: 6 adds offered, 5 fit
        res_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = (sent < 6);
            cmd_op = 2'b00; cmd_a = 5'(sent); cmd_b = 5'd10; cmd_tag = 3'(sent);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) sent++;
        end
        chk("bp_accepted", sent, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_busy", busy, 1);
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            cmd_valid = (sent < 6);
            cmd_a = 5'(sent); cmd_tag = 3'(sent);
            acc = cmd_valid && cmd_ready;
            if (res_valid) begin
                chk("bp_tag", res_tag, got);
                chk("bp_data", res_data, got + 10);
                got++;
            end
            tick();
            if (acc) sent++;
        end
        cmd_valid = 1'b0;
        chk("bp_count", got, 6);
        tick();
        chk("bp_busy_drop", busy, 0);

        // reset during EXEC of a mul with three commands queued
        res_ready = 1'b0;
        send(2'b00, 5'd1, 5'd1, 3'd7);
        send(2'b10, 5'd7, 5'd3, 3'd1);
        send(2'b00, 5'd2, 5'd2, 3'd2);
        send(2'b00, 5'd3, 5'd3, 3'd3);
        send(2'b00, 5'd4, 5'd4, 3'd4);
        chk("rm_hold_tag", res_tag, 7);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rm_exec_ops", {alu_a, alu_b, alu_op1}, {5'd7, 5'd3, 1'b1});
        chk("rm_exec_nvalid", res_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_res_valid", res_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_cmd_ready", cmd_ready, 1);
        chk("rm_alu", {alu_a, alu_b, alu_op1, alu_op0}, 0);
        res_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (res_valid) vcnt++;
        end
        chk("rm_no_stale", vcnt, 0);
        send(2'b00, 5'd1, 5'd2, 3'd6);
        wait_res(lat);
        chk("rm_after_lat", lat, 2);
        chk("rm_after_data", {res_tag, res_data}, {3'd6, 11'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
